// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA VRAM controller slice.
package vga_pkg;

  localparam int unsigned SramDataWidth      = 16;
  localparam int unsigned StarveLimitDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWrSetup,
    StWrPulse
  } vram_state_e;

endpackage

// File: rtl/vga_vram_arbiter.sv
// Read/write arbitration between display reads and host writes, with a
// starvation counter that forces a pending host write through.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rd_req_i,
  input  logic wr_req_i,
  input  logic idle_i,
  output logic rd_grant_o,
  output logic wr_grant_o,
  output logic busy_o
);

  // One spare bit keeps the width non-zero even for a limit of 0.
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

  logic [CntW-1:0] cnt_q;
  logic            starved;

  assign starved = (cnt_q == CntW'(STARVE_LIMIT));

  always_comb begin
    wr_grant_o = idle_i & ~rst_i & wr_req_i & (~rd_req_i | starved);
    // A write granted while a read is pending can only be a forced one.
    busy_o     = ~idle_i | (wr_grant_o & rd_req_i);
    rd_grant_o = rd_req_i & ~busy_o & ~rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!wr_req_i || wr_grant_o) begin
      cnt_q <= '0;
    end else if (rd_grant_o && !starved) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/vga_vram_ctrl.sv
// Shares an async 16-bit SRAM between a 2-cycle-latency display read port and
// a byte-wide host write port (only PWIDTH = 8 is supported).
module vga_vram_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned AWIDTH       = 19,
  parameter int unsigned PWIDTH       = 8,
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
  input  logic                     vram_rd,
  input  logic [AWIDTH-1:0]        vram_addr,
  output logic                     vram_busy,
  output logic [PWIDTH-1:0]        vram_data,
  output logic                     vram_vld,
  input  logic                     host_wr,
  input  logic [AWIDTH-1:0]        host_addr,
  input  logic [PWIDTH-1:0]        host_wdata,
  output logic                     host_ack,
  output logic [AWIDTH-2:0]        sram_addr,
  input  logic [SramDataWidth-1:0] sram_dq_i,
  output logic [SramDataWidth-1:0] sram_dq_o,
  output logic                     sram_dq_oe,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n
);

  vram_state_e state_q;
  logic        rd_grant;
  logic        wr_grant;
  logic        rd_p1_q;
  logic        sel_p1_q;

  vga_vram_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbiter (
    .clk_i     (clk_core),
    .rst_i     (rst_core),
    .rd_req_i  (vram_rd),
    .wr_req_i  (host_wr),
    .idle_i    (state_q == StIdle),
    .rd_grant_o(rd_grant),
    .wr_grant_o(wr_grant),
    .busy_o    (vram_busy)
  );

  assign host_ack = wr_grant;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q    <= StIdle;
      rd_p1_q    <= 1'b0;
      sel_p1_q   <= 1'b0;
      vram_vld   <= 1'b0;
      vram_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      // Read pipeline: SRAM cycle in T+1, captured data presented in T+2.
      rd_p1_q  <= rd_grant;
      sel_p1_q <= vram_addr[0];
      vram_vld <= rd_p1_q;
      if (rd_p1_q) begin
        vram_data <= sel_p1_q ? sram_dq_i[2*PWIDTH-1:PWIDTH] : sram_dq_i[PWIDTH-1:0];
      end

      unique case (state_q)
        StIdle: begin
          if (wr_grant) begin
            // Latch everything now so the host may move on after host_ack.
            state_q    <= StWrSetup;
            sram_addr  <= host_addr[AWIDTH-1:1];
            sram_dq_o  <= {host_wdata, host_wdata};
            sram_dq_oe <= 1'b1;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= host_addr[0];
            sram_ub_n  <= ~host_addr[0];
          end else if (rd_grant) begin
            sram_addr  <= vram_addr[AWIDTH-1:1];
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b0;
            sram_lb_n  <= 1'b0;
          end else begin
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
          end
        end
        StWrSetup: begin
          state_q   <= StWrPulse;
          sram_we_n <= 1'b0;
        end
        StWrPulse: begin
          // Reads are blocked during the pulse, so the bus always goes idle here.
          state_q    <= StIdle;
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/vga_vram_ctrl.md
VGA_VRAM_CTRL -- requirements
Module: vga_vram_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is clk_core, and the reset is rst_core, which is synchronous and active-high.
REQ-002 Parameters (name, default, meaning) SHALL be:
- AWIDTH, 19, pixel byte address width.
- PWIDTH, 8, pixel width; only 8 is supported.
- STARVE_LIMIT, 16, consecutive read grants allowed while a host write waits.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk_core, in, 1, core clock.
- rst_core, in, 1, sync active-high reset.
- vram_rd, in, 1, display read request.
- vram_addr, in, AWIDTH, display byte address.
- vram_busy, out, 1, read not accepted this cycle.
- vram_data, out, PWIDTH, read pixel.
- vram_vld, out, 1, vram_data valid.
- host_wr, in, 1, host write request, held until ack.
- host_addr, in, AWIDTH, host byte address.
- host_wdata, in, PWIDTH, host write data.
- host_ack, out, 1, one-cycle write accept pulse.
- sram_addr, out, AWIDTH-1, SRAM word address.
- sram_dq_i, in, 16, SRAM read data.
- sram_dq_o, out, 16, SRAM write data.
- sram_dq_oe, out, 1, tristate enable for dq.
- sram_ce_n, out, 1, active-low chip enable.
- sram_oe_n, out, 1, active-low output enable.
- sram_we_n, out, 1, active-low write enable.
- sram_ub_n, out, 1, active-low upper byte enable.
- sram_lb_n, out, 1, active-low lower byte enable.

Function
REQ-004 A read SHALL be accepted in cycle T when vram_rd=1 and vram_busy=0.
REQ-005 All SRAM outputs SHALL be registered; an accepted read SHALL drive sram_addr=vram_addr[AWIDTH-1:1], ce_n=0, oe_n=0, ub_n=lb_n=0 and dq_oe=0 in T+1.
REQ-006 sram_dq_i SHALL be captured at the end of T+1; vram_vld SHALL be 1 in T+2, and vram_data SHALL be dq[7:0] if the address bit 0 was 0, else dq[15:8]. Fixed latency is 2.
REQ-007 Back-to-back reads SHALL sustain one read per cycle, with vram_vld order equal to request order.
REQ-008 The FSM SHALL have three states: IDLE, WR_SETUP, WR_PULSE.
REQ-009 In IDLE, a host write SHALL be granted when host_wr=1 and either no read is requested, or the starvation counter equals STARVE_LIMIT.
- On grant: host_ack=1 that cycle, and the next state is WR_SETUP.
REQ-010 WR_SETUP SHALL drive:
- sram_addr=host_addr[AWIDTH-1:1];
- sram_dq_o={host_wdata,host_wdata};
- dq_oe=1, ce_n=0, oe_n=1, we_n=1;
- lb_n=host_addr[0], ub_n=~host_addr[0].
The next state is WR_PULSE.
REQ-011 WR_PULSE SHALL hold the same address, data and enables with we_n=0; the next state is IDLE.
REQ-012 The address, data and byte lane SHALL be latched at grant, so host inputs may change after host_ack.
REQ-013 vram_busy SHALL be 1 in these cases:
- in the grant cycle of a starvation-forced write;
- in WR_SETUP;
- in WR_PULSE.
Otherwise vram_busy SHALL be 0.
REQ-014 The starvation counter SHALL behave as follows:
- it increments on each read grant while host_wr=1;
- it saturates at STARVE_LIMIT;
- it clears on write grant or when host_wr=0.
REQ-015 When vram_rd and host_wr arrive in the same cycle and the counter is below STARVE_LIMIT, the read SHALL win.
REQ-016 A read in flight at write grant SHALL complete normally: its SRAM cycle precedes WR_SETUP, so there is no dq contention.
REQ-017 When the bus is idle, the SRAM outputs SHALL be ce_n=1, oe_n=1, we_n=1, ub_n=lb_n=1, dq_oe=0.
REQ-018 sram_dq_oe SHALL never be 1 in a cycle where sram_oe_n=0.

Reset
REQ-019 While rst_core=1 at a clock edge, the block SHALL load:
- state=IDLE and counter=0;
- vram_vld=0, vram_data=0, host_ack=0, vram_busy=0;
- sram_ce_n=oe_n=we_n=ub_n=lb_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
REQ-020 Reset mid-write SHALL abort the write; we_n SHALL be 1 the cycle after reset is sampled, and no host_ack SHALL follow.
REQ-021 Reset mid-read SHALL drop in-flight reads; no vram_vld SHALL be asserted for them.

Structure
REQ-022 The state encoding, the SRAM data width (16) and the default STARVE_LIMIT SHALL live in the shared package vga_pkg.
REQ-023 The arbitration and starvation counter SHALL be a sub-module, vga_vram_arbiter; the datapath and FSM SHALL remain in vga_vram_ctrl.

Verification
REQ-024 Single read: vram_addr=0x00003 with dq_i=0xA55A -> sram_addr=0x00001 in T+1; vram_vld=1 with vram_data=0xA5 in T+2.
REQ-025 Burst read: 8 consecutive reads of 0..7 -> 8 consecutive vld cycles in order, and vram_busy stays 0.
REQ-026 Write: host_addr=0x00010, wdata=0x3C -> host_ack in T, then WR_SETUP with lb_n=0, ub_n=1, dq_o=0x3C3C, then we_n=0 for exactly one cycle.
REQ-027 Starvation: continuous vram_rd with host_wr held -> 16 read grants, then host_ack with vram_busy=1 for 3 cycles, then reads resume.
REQ-028 Reset in WR_PULSE -> we_n=1 and dq_oe=0 the next cycle, with no host_ack; reset with 2 reads in flight -> no vram_vld.
